controller_sequencer: RTL

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

---
 rtl/sap1_pkg.sv | 47 ++++
 rtl/ring_counter.sv | 21 ++
 rtl/controller_sequencer.sv | 79 +++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 shared opcodes, control-word bit map and constants
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    localparam logic [11:0] CON_NOP    = 12'h3E3;
    localparam logic [11:0] CON_T1     = 12'h5E3;
    localparam logic [11:0] CON_T2     = 12'hBE3;
    localparam logic [11:0] CON_T3     = 12'h263;
    localparam logic [11:0] CON_ADDR   = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
    localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4 = 12'h3F2;

    localparam logic [5:0] TS_T1 = 6'b000001;
    localparam logic [5:0] TS_T2 = 6'b000010;
    localparam logic [5:0] TS_T3 = 6'b000100;
    localparam logic [5:0] TS_T4 = 6'b001000;
    localparam logic [5:0] TS_T5 = 6'b010000;
    localparam logic [5:0] TS_T6 = 6'b100000;

    function automatic logic is_one_hot(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - 6-bit one-hot T-state ring with hold and self-recovery
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    output logic [5:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= TS_T1;
        end else if (!is_one_hot(q)) begin
            q <= TS_T1;
        end else if (!hold) begin
            q <= {q[4:0], q[5]};
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 controller: T-state ring plus combinational control-word decode
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int CON_WIDTH    = 12
) (
    input  logic                    CLK_n,
    input  logic                    CLR,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [CON_WIDTH-1:0]    con,
    output logic [5:0]              t_state,
    output logic                    HLT
);

    logic        halt_flag;
    logic        hlt_decode;
    logic [11:0] con_word;

    assign hlt_decode = !halt_flag && (t_state == TS_T4)
                        && (opcode == OPCODE_WIDTH'(OP_HLT));

    // The ring must not leave T4 on the edge that latches the halt flag.
    ring_counter u_ring (
        .clk  (CLK_n),
        .clr  (CLR),
        .hold (halt_flag | hlt_decode),
        .q    (t_state)
    );

    always_ff @(posedge CLK_n) begin
        if (CLR) begin
            halt_flag <= 1'b0;
        end else if (hlt_decode) begin
            halt_flag <= 1'b1;
        end
    end

    assign HLT = !CLR && (halt_flag || hlt_decode);

    always_comb begin
        con_word = CON_NOP;
        if (!CLR && !halt_flag) begin
            case (t_state)
                TS_T1: con_word = CON_T1;
                TS_T2: con_word = CON_T2;
                TS_T3: con_word = CON_T3;
                TS_T4: begin
                    case (opcode)
                        OPCODE_WIDTH'(OP_LDA),
                        OPCODE_WIDTH'(OP_ADD),
                        OPCODE_WIDTH'(OP_SUB): con_word = CON_ADDR;
                        OPCODE_WIDTH'(OP_OUT): con_word = CON_OUT_T4;
                        default:               con_word = CON_NOP;
                    endcase
                end
                TS_T5: begin
                    case (opcode)
                        OPCODE_WIDTH'(OP_LDA): con_word = CON_LDA_T5;
                        OPCODE_WIDTH'(OP_ADD),
                        OPCODE_WIDTH'(OP_SUB): con_word = CON_ALU_T5;
                        default:               con_word = CON_NOP;
                    endcase
                end
                TS_T6: begin
                    case (opcode)
                        OPCODE_WIDTH'(OP_ADD): con_word = CON_ADD_T6;
                        OPCODE_WIDTH'(OP_SUB): con_word = CON_SUB_T6;
                        default:               con_word = CON_NOP;
                    endcase
                end
                default: con_word = CON_NOP;
            endcase
        end
    end

    assign con = CON_WIDTH'(con_word);

endmodule
